// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
// Holds the default reset vector, the NOP used for faulted fetches, the
// queue entry struct and the ROM-window helper.
package fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_ROM_BYTES    = 32'h0000_1000;
  localparam logic [DATA_W-1:0] NOP_INSTR            = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              fault;
  } fetch_entry_t;

  // An unsigned offset from the window base is in range exactly when it is
  // below the window size, which also covers addresses below the base.
  function automatic logic in_rom_window(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] size);
    logic [ADDR_W-1:0] offset;
    offset = addr - base;
    return (offset < size);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: ROM, redirect and decode-handshake signals of the fetch unit.
// master = fetch unit side, slave = environment (ROM, execute, decode).
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instr;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;
  logic                  out_fault;

  modport master (
    output pc,
    input  instr,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_fault
  );

  modport slave (
    input  pc,
    output instr,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_fault
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetch entries. Entry 0 is always the head.
// Flush wins over push/pop; push while full is accepted only with a pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok_s;
  logic         push_ok_s;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign count     = count_q;
  assign head      = e0_q;
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Next-state of the two slots and the occupancy count.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_d = push_entry;
          end else begin
            e1_d = push_entry;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = push_entry;
          end else begin
            e0_d = push_entry;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Slot and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, fetch fire logic and optional ROM range check
// in front of a 2-entry fetch queue.
// Optional feature macro: FETCH_RANGE_CHECK_EN -- fetches outside the ROM
// window are queued as NOP with the fault bit set.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDR_WIDTH   = 32,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [ADDR_WIDTH-1:0]    ROM_BYTES    = DEFAULT_ROM_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  // The queue entry type is fixed-width; reject configurations it cannot hold.
  if ((ADDR_WIDTH != ADDR_W) || (DATA_WIDTH != DATA_W) || (ROM_BYTES == '0)) begin : g_bad_cfg
    $error("fetch_unit: unsupported width or empty ROM window");
  end

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] target_s;
  logic [DATA_WIDTH-1:0] instr_s;
  logic                  fault_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  fire_s;
  logic [1:0]            count_s;
  logic                  full_s;
  logic                  empty_s;
  fetch_entry_t          head_s;
  fetch_entry_t          push_entry_s;

  // Redirect masks the head so decode never consumes a wrong-path entry.
  assign valid_s  = (count_s != 2'd0) && !bus.redirect;
  assign pop_s    = valid_s && bus.out_ready;
  assign fire_s   = !bus.redirect && (!full_s || pop_s);
  assign target_s = bus.redirect_pc & ~ADDR_WIDTH'(3);

  // Range check on the fetched word (passthrough when the feature is off).
  always_comb begin
    instr_s = bus.instr;
    fault_s = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
    if (!in_rom_window(pc_q, RESET_VECTOR, ROM_BYTES)) begin
      instr_s = NOP_INSTR;
      fault_s = 1'b1;
    end else begin
      instr_s = bus.instr;
      fault_s = 1'b0;
    end
`else
    instr_s = bus.instr;
    fault_s = 1'b0;
`endif
  end

  assign push_entry_s = '{pc: pc_q, instr: instr_s, fault: fault_s};

  // PC next-state: redirect first, then advance on fire, else hold.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect) begin
      pc_d = target_s;
    end else if (fire_s) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end else begin
      pc_d = pc_q;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (fire_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (bus.redirect),
    .head       (head_s),
    .count      (count_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  assign bus.pc        = pc_q;
  assign bus.out_valid = valid_s;
  assign bus.out_pc    = empty_s ? '0 : head_s.pc;
  assign bus.out_instr = empty_s ? '0 : head_s.instr;
  assign bus.out_fault = empty_s ? 1'b0 : head_s.fault;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end sitting directly upstream of the asynchronous instruction ROM and downstream of execute's redirect logic. Owns the program counter, drives it to the ROM, captures the combinationally returned instruction together with its PC into a 2-entry fetch queue, and hands entries to decode over a valid/ready handshake. Redirects from execute (taken branch, JAL, JALR) flush the queue and reload the PC.

## Interface
- `ADDR_WIDTH`, 32: PC width in bits.
- `DATA_WIDTH`, 32: instruction width in bits.
- `RESET_VECTOR`, 32'hBFC00000: PC after reset; also the ROM window base.
- `ROM_BYTES`, 32'h1000: ROM window size in bytes; used only by the range check.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  out  ADDR_WIDTH  fetch address to instruction ROM.
- `instr`  in  DATA_WIDTH  ROM data for `pc`, valid in the same cycle (combinational ROM).
- `redirect`  in  1  execute requests a PC change this cycle.
- `redirect_pc`  in  ADDR_WIDTH  new fetch target; bits [1:0] ignored.
- `out_valid`  out  1  queue head is valid for decode.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_pc`  out  ADDR_WIDTH  PC of head entry.
- `out_instr`  out  DATA_WIDTH  instruction of head entry.
- `out_fault`  out  1  head entry was fetched outside the ROM window.

## Operation
- Reset: `pc` = RESET_VECTOR, queue empty, `out_valid` = 0, `out_pc`/`out_instr` = 0, `out_fault` = 0.
- Fetch fire condition: `!redirect && (count < 2 || pop)`, where `pop = out_valid && out_ready`.
- On fire: push {pc, instr, fault} into queue; `pc` <= `pc + 4` (wraps modulo 2^ADDR_WIDTH).
- On no fire and no redirect: `pc` holds; ROM output ignored.
- Redirect (highest priority): queue cleared, `pc` <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}, nothing pushed. `out_valid` is masked to 0 combinationally in the redirect cycle, so decode cannot consume a wrong-path entry.
- Queue: 2 entries, FIFO order, count 0..2; simultaneous push and pop when full is legal, count stays 2; push and pop when count==1 keeps count 1 with the new entry at tail.
- `out_*` reflect the head entry; they are 0 when the queue is empty.

## Timing
- PC to decode latency: 1 cycle (fetch in cycle N, `out_valid` in cycle N+1).
- First `out_valid` one cycle after the first clock edge following `rst` deassertion; head `out_pc` = RESET_VECTOR.
- Sustained throughput: 1 instruction/cycle with `out_ready` held high.
- Backpressure: with `out_ready` low, queue fills in 2 cycles, then `pc` holds at head+8.
- Redirect in cycle N: queue empty in N+1, first target entry valid in N+2.
- `rst` asserted mid-operation: immediate return to reset state, no partial push.

## Configuration
- `FETCH_RANGE_CHECK_EN` defined: an entry whose PC lies outside [RESET_VECTOR, RESET_VECTOR+ROM_BYTES) is pushed with `instr` replaced by NOP 32'h00000013 and fault=1; PC still advances normally.
- Not defined: `instr` passed through unmodified, `out_fault` tied 0, no comparator logic.

## Structure
- `fetch_pkg`: `RESET_VECTOR` default, `NOP_INSTR`, `fetch_entry_t` struct {pc, instr, fault}.
- One sub-module: `fetch_queue`, a 2-entry synchronous FIFO of `fetch_entry_t` with push/pop/flush, count, full/empty; `fetch_unit` holds PC register, fire logic and range check.

## Test plan
- Reset then `out_ready`=1 for 4 cycles -> `out_pc` sequence BFC00000, BFC00004, BFC00008, BFC0000C, one per cycle, `out_instr` matching ROM words.
- `out_ready`=0 from first valid -> after 2 pushes count=2, `pc` holds BFC00008; release -> heads BFC00000 then BFC00004 drained in order, no drops or duplicates.
- Redirect to 32'hBFC00043 while queue full -> `out_valid`=0 that cycle, next cycle empty, following cycle head `out_pc`=BFC00040.
- Redirect and `out_ready`=1 same cycle -> head not consumed, no entry from old path ever appears.
- With `FETCH_RANGE_CHECK_EN`, redirect to 32'hBFC01000 -> `out_fault`=1, `out_instr`=00000013; redirect to BFC00FFC -> `out_fault`=0, and next entry BFC01000 faults.
- `rst` pulsed mid-stream with queue holding 1 entry -> `out_valid` drops immediately, fetch restarts at BFC00000.
